// File: rtl/alu_operand_stage.sv
// ID/EX operand stage: EX pipeline register, MEM/WB forwarding into the ALU
// operands, load-use stall detection and bubble insertion on stall or flush.
module alu_operand_stage #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,

   input  logic            validd,
   input  logic [4:0]      rs1d,
   input  logic [4:0]      rs2d,
   input  logic [4:0]      rdd,
   input  logic [XLEN-1:0] rd1d,
   input  logic [XLEN-1:0] rd2d,
   input  logic [XLEN-1:0] immextd,
   input  logic            alusrcd,
   input  logic [2:0]      alucontrold,
   input  logic            regwrited,
   input  logic            memreadd,

   input  logic            flushe,

   input  logic [4:0]      rdm,
   input  logic            regwritem,
   input  logic [XLEN-1:0] aluresultm,
   input  logic [4:0]      rdw,
   input  logic            regwritew,
   input  logic [XLEN-1:0] resultw,

   output logic [XLEN-1:0] srcae,
   output logic [XLEN-1:0] srcbe,
   output logic [XLEN-1:0] writedatae,
   output logic [2:0]      alucontrole,
   output logic [4:0]      rde,
   output logic            regwritee,
   output logic            memreade,
   output logic            valide,
   output logic            stalld
);

   localparam int unsigned REG_W = 5;
   localparam int unsigned OP_W  = 3;

   typedef struct packed {
      logic             valid;
      logic [REG_W-1:0] rs1;
      logic [REG_W-1:0] rs2;
      logic [REG_W-1:0] rd;
      logic [XLEN-1:0]  rd1;
      logic [XLEN-1:0]  rd2;
      logic [XLEN-1:0]  imm;
      logic             alusrc;
      logic [OP_W-1:0]  alucontrol;
      logic             regwrite;
      logic             memread;
   } ex_reg_t;

   ex_reg_t         ex_q;
   ex_reg_t         ex_d;
   logic [XLEN-1:0] fwd_a_c;
   logic [XLEN-1:0] fwd_b_c;

   // Load-use hazard: a load in EX whose rd is read by the decode instruction.
   // rs2 is compared even for immediate forms, which is conservative but safe.
   always_comb begin
      stalld = 1'b0;
      if (ex_q.valid && ex_q.memread && (ex_q.rd != '0) && validd &&
          ((rs1d == ex_q.rd) || (rs2d == ex_q.rd))) begin
         stalld = 1'b1;
      end
   end

   // Next EX contents: bubble on flush or stall, otherwise the decode inputs.
   always_comb begin
      ex_d = '0;
      if (!flushe && !stalld) begin
         ex_d.valid      = validd;
         ex_d.rs1        = rs1d;
         ex_d.rs2        = rs2d;
         ex_d.rd         = rdd;
         ex_d.rd1        = rd1d;
         ex_d.rd2        = rd2d;
         ex_d.imm        = immextd;
         ex_d.alusrc     = alusrcd;
         ex_d.alucontrol = alucontrold;
         ex_d.regwrite   = regwrited;
         ex_d.memread    = memreadd;
      end
   end

   // EX pipeline register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ex_q <= '0;
      end else begin
         ex_q <= ex_d;
      end
   end

   // Operand A forward: MEM beats WB, x0 is never forwarded.
   always_comb begin
      fwd_a_c = ex_q.rd1;
      if (regwritem && (rdm != '0) && (rdm == ex_q.rs1)) begin
         fwd_a_c = aluresultm;
      end else if (regwritew && (rdw != '0) && (rdw == ex_q.rs1)) begin
         fwd_a_c = resultw;
      end
   end

   // Operand B forward: same rules as A, keyed on rs2.
   always_comb begin
      fwd_b_c = ex_q.rd2;
      if (regwritem && (rdm != '0) && (rdm == ex_q.rs2)) begin
         fwd_b_c = aluresultm;
      end else if (regwritew && (rdw != '0) && (rdw == ex_q.rs2)) begin
         fwd_b_c = resultw;
      end
   end

   // ALU-facing outputs; a bubble presents add 0+0.
   always_comb begin
      srcae       = fwd_a_c;
      writedatae  = fwd_b_c;
      srcbe       = ex_q.alusrc ? ex_q.imm : fwd_b_c;
      alucontrole = ex_q.alucontrol;
      rde         = ex_q.rd;
      regwritee   = ex_q.regwrite;
      memreade    = ex_q.memread;
      valide      = ex_q.valid;
   end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: reset, forwarding priority, x0 guard,
// immediate routing, load-use stall, flush, and asynchronous reset.
module tb_alu_operand_stage;

   localparam int unsigned XLEN = 32;

   logic            clk;
   logic            reset;
   logic            validd;
   logic [4:0]      rs1d, rs2d, rdd;
   logic [XLEN-1:0] rd1d, rd2d, immextd;
   logic            alusrcd;
   logic [2:0]      alucontrold;
   logic            regwrited, memreadd;
   logic            flushe;
   logic [4:0]      rdm, rdw;
   logic            regwritem, regwritew;
   logic [XLEN-1:0] aluresultm, resultw;
   logic [XLEN-1:0] srcae, srcbe, writedatae;
   logic [2:0]      alucontrole;
   logic [4:0]      rde;
   logic            regwritee, memreade, valide, stalld;

   int n_cmp;
   int n_fail;

   alu_operand_stage #(.XLEN(XLEN)) dut (
      .clk(clk), .reset(reset),
      .validd(validd), .rs1d(rs1d), .rs2d(rs2d), .rdd(rdd),
      .rd1d(rd1d), .rd2d(rd2d), .immextd(immextd), .alusrcd(alusrcd),
      .alucontrold(alucontrold), .regwrited(regwrited), .memreadd(memreadd),
      .flushe(flushe),
      .rdm(rdm), .regwritem(regwritem), .aluresultm(aluresultm),
      .rdw(rdw), .regwritew(regwritew), .resultw(resultw),
      .srcae(srcae), .srcbe(srcbe), .writedatae(writedatae),
      .alucontrole(alucontrole), .rde(rde), .regwritee(regwritee),
      .memreade(memreade), .valide(valide), .stalld(stalld)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic dec(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                      input logic [4:0] rd, input logic [XLEN-1:0] d1,
                      input logic [XLEN-1:0] d2, input logic [XLEN-1:0] imm,
                      input logic asrc, input logic [2:0] op,
                      input logic rw, input logic mr);
      validd = v; rs1d = r1; rs2d = r2; rdd = rd; rd1d = d1; rd2d = d2;
      immextd = imm; alusrcd = asrc; alucontrold = op; regwrited = rw; memreadd = mr;
   endtask

   task automatic no_fwd();
      rdm = 5'd0; regwritem = 1'b0; aluresultm = '0;
      rdw = 5'd0; regwritew = 1'b0; resultw = '0;
   endtask

   task automatic rand_in();
      dec(1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), $urandom, $urandom,
          $urandom, 1'($urandom), 3'($urandom), 1'($urandom), 1'($urandom));
      flushe = 1'($urandom);
      rdm = 5'($urandom); regwritem = 1'($urandom); aluresultm = $urandom;
      rdw = 5'($urandom); regwritew = 1'($urandom); resultw = $urandom;
   endtask

   initial begin
      n_cmp = 0;
      n_fail = 0;
      reset = 1'b0;
      rand_in();
      #2;
      // Reset held low: everything zero, no stall
      chk("rst_srcae", srcae, 0);
      chk("rst_srcbe", srcbe, 0);
      chk("rst_wdata", writedatae, 0);
      chk("rst_ctrl", {alucontrole, rde, regwritee, memreade, valide}, 0);
      chk("rst_stall", stalld, 0);
      for (int i = 0; i < 3; i++) begin
         rand_in();
         tick();
         chk("rst_hold_ctrl", {alucontrole, rde, regwritee, memreade, valide, stalld}, 0);
         chk("rst_hold_data", {srcae, srcbe}, 0);
      end

      // Release reset, add x3, x1, x2 with rd1=5 rd2=7
      reset = 1'b1;
      flushe = 1'b0;
      no_fwd();
      dec(1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 0, 3'b000, 1, 0);
      tick();
      chk("add_srcae", srcae, 5);
      chk("add_srcbe", srcbe, 7);
      chk("add_ctrl", alucontrole, 0);
      chk("add_valid", valide, 1);
      chk("add_rde", rde, 3);
      chk("add_rw", regwritee, 1);

      // MEM over WB priority, both operands rs=4
      dec(1, 5'd4, 5'd4, 5'd7, 32'hA, 32'hB, 32'd0, 0, 3'b010, 1, 0);
      tick();
      chk("nofwd_a", srcae, 32'hA);
      chk("nofwd_b", srcbe, 32'hB);
      rdm = 5'd4; regwritem = 1'b1; aluresultm = 32'h11;
      rdw = 5'd4; regwritew = 1'b1; resultw = 32'h22;
      #1;
      chk("memfwd_a", srcae, 32'h11);
      chk("memfwd_b", srcbe, 32'h11);
      chk("memfwd_wd", writedatae, 32'h11);
      regwritem = 1'b0;
      #1;
      chk("wbfwd_a", srcae, 32'h22);
      chk("wbfwd_b", srcbe, 32'h22);
      rdm = 5'd5; regwritem = 1'b1;
      #1;
      chk("rdm_miss_a", srcae, 32'h22);

      // x0 guard
      no_fwd();
      dec(1, 5'd0, 5'd0, 5'd1, 32'd0, 32'd0, 32'd0, 0, 3'b000, 1, 0);
      tick();
      rdm = 5'd0; regwritem = 1'b1; aluresultm = 32'hFFFF_FFFF;
      rdw = 5'd0; regwritew = 1'b1; resultw = 32'hDEAD;
      #1;
      chk("x0_srcae", srcae, 0);
      chk("x0_srcbe", srcbe, 0);

      // Immediate select with rs2 forwarded from MEM
      no_fwd();
      dec(1, 5'd1, 5'd9, 5'd10, 32'd3, 32'd4, 32'hFFFF_FFF0, 1, 3'b000, 1, 0);
      tick();
      rdm = 5'd9; regwritem = 1'b1; aluresultm = 32'h55;
      #1;
      chk("imm_srcbe", srcbe, 32'hFFFF_FFF0);
      chk("imm_wdata", writedatae, 32'h55);
      chk("imm_srcae", srcae, 3);

      // Load-use: lw x5 then add x6, x5, x1
      no_fwd();
      dec(1, 5'd2, 5'd0, 5'd5, 32'h40, 32'd0, 32'd8, 1, 3'b000, 1, 1);
      #1;
      chk("lw_dec_nostall", stalld, 0);
      tick();
      dec(1, 5'd5, 5'd1, 5'd6, 32'h999, 32'h100, 32'd0, 0, 3'b000, 1, 0);
      #1;
      chk("lu_stall", stalld, 1);
      chk("lu_memrd", memreade, 1);
      chk("lu_rde", rde, 5);
      tick();
      chk("bub_valid", valide, 0);
      chk("bub_rw", regwritee, 0);
      chk("bub_ctrl", {alucontrole, rde, memreade}, 0);
      chk("bub_data", {srcae, srcbe}, 0);
      chk("bub_nostall", stalld, 0);
      tick();
      rdw = 5'd5; regwritew = 1'b1; resultw = 32'hCAFE;
      #1;
      chk("lu_add_srcae", srcae, 32'hCAFE);
      chk("lu_add_srcbe", srcbe, 32'h100);
      chk("lu_add_valid", valide, 1);
      chk("lu_add_rde", rde, 6);

      // Load to x0 never stalls
      no_fwd();
      dec(1, 5'd2, 5'd0, 5'd0, 32'd0, 32'd0, 32'd4, 1, 3'b000, 1, 1);
      tick();
      dec(1, 5'd0, 5'd0, 5'd6, 32'd0, 32'd0, 32'd0, 0, 3'b000, 1, 0);
      #1;
      chk("x0_load_nostall", stalld, 0);

      // Flush a valid sub
      dec(1, 5'd1, 5'd2, 5'd7, 32'd20, 32'd8, 32'd0, 0, 3'b001, 1, 0);
      flushe = 1'b1;
      tick();
      flushe = 1'b0;
      chk("fl_valid", valide, 0);
      chk("fl_rw", regwritee, 0);
      chk("fl_ctrl", alucontrole, 0);
      dec(1, 5'd3, 5'd4, 5'd8, 32'h0F, 32'h3C, 32'd0, 0, 3'b010, 1, 0);
      tick();
      chk("post_fl_valid", valide, 1);
      chk("post_fl_ops", {srcae, srcbe}, {32'h0F, 32'h3C});
      chk("post_fl_ctrl", {alucontrole, rde}, {3'b010, 5'd8});

      // Flush and stall together still give a bubble
      dec(1, 5'd2, 5'd0, 5'd9, 32'd0, 32'd0, 32'd0, 1, 3'b000, 1, 1);
      tick();
      dec(1, 5'd9, 5'd9, 5'd10, 32'd1, 32'd2, 32'd0, 0, 3'b011, 1, 0);
      flushe = 1'b1;
      #1;
      chk("fs_stall", stalld, 1);
      tick();
      flushe = 1'b0;
      chk("fs_bubble", {valide, regwritee, memreade, rde, alucontrole}, 0);

      // Asynchronous reset mid-cycle, then normal load on first edge
      dec(1, 5'd1, 5'd2, 5'd11, 32'd100, 32'd200, 32'd0, 0, 3'b100, 1, 0);
      tick();
      chk("pre_arst_valid", valide, 1);
      #2;
      reset = 1'b0;
      #1;
      chk("arst_clear", {valide, regwritee, rde, alucontrole}, 0);
      chk("arst_data", {srcae, srcbe}, 0);
      reset = 1'b1;
      dec(1, 5'd1, 5'd2, 5'd12, 32'd33, 32'd44, 32'd0, 0, 3'b101, 1, 0);
      tick();
      chk("arst_rel_ops", {srcae, srcbe}, {32'd33, 32'd44});
      chk("arst_rel_ctrl", {valide, rde, alucontrole}, {1'b1, 5'd12, 3'b101});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
